// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: skid state encoding and default field widths.
// Every per-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) draws its widths from here.
package pipe_pkg;

   localparam int PIPE_CTRL_W = 4;
   localparam int PIPE_DATA_W = 69;
   localparam int PIPE_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline register with flush and saturating stall statistics.
// in_ready is a flop, so downstream out_ready never reaches the upstream stage combinationally.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int DATA_W = PIPE_DATA_W,
   parameter int CNT_W  = PIPE_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output skid_state_e       state_dbg
);

   // Handshake: an entry moves on any cycle where valid and ready are both 1 at the
   // rising edge; valid never depends on ready, and in_ready never depends on out_ready.

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   skid_state_e       state;
   logic              in_ready_r;
   logic              out_valid_r;
   logic [CTRL_W-1:0] out_ctrl_r;
   logic [DATA_W-1:0] out_data_r;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [CNT_W-1:0]  stall_r;
   logic              accept;
   logic              xfer;

   assign accept = in_valid && in_ready_r;
   assign xfer   = out_valid_r && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_EMPTY;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_ctrl_r  <= '0;
         out_data_r  <= '0;
         skid_ctrl   <= '0;
         skid_data   <= '0;
      end else if (flush) begin
         state       <= ST_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_ctrl_r  <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               in_ready_r <= 1'b1;
               if (accept) begin
                  state       <= ST_ONE;
                  out_valid_r <= 1'b1;
                  out_ctrl_r  <= in_ctrl;
                  out_data_r  <= in_data;
               end
            end
            ST_ONE: begin
               if (accept && xfer) begin
                  out_ctrl_r <= in_ctrl;
                  out_data_r <= in_data;
               end else if (accept) begin
                  // Output is stuck: park the newcomer and stop the upstream.
                  state      <= ST_TWO;
                  in_ready_r <= 1'b0;
                  skid_ctrl  <= in_ctrl;
                  skid_data  <= in_data;
               end else if (xfer) begin
                  state       <= ST_EMPTY;
                  out_valid_r <= 1'b0;
                  out_ctrl_r  <= '0;
               end
            end
            ST_TWO: begin
               if (xfer) begin
                  state      <= ST_ONE;
                  in_ready_r <= 1'b1;
                  out_ctrl_r <= skid_ctrl;
                  out_data_r <= skid_data;
               end
            end
            default: begin
               state       <= ST_EMPTY;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               out_ctrl_r  <= '0;
            end
         endcase
      end
   end

   // Statistics survive flush; only reset clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_r <= '0;
      end else if (out_valid_r && !out_ready && (stall_r != CNT_MAX)) begin
         stall_r <= stall_r + 1'b1;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_ctrl  = out_ctrl_r;
   assign out_data  = out_data_r;
   assign stall_cnt = stall_r;
   assign state_dbg = state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: streaming, bubbles, backpressure, flush,
// stall saturation and asynchronous reset in the middle of traffic.
module tb_pipe_skid_stage;
   import pipe_pkg::*;

   localparam int CTRL_W = 4;
   localparam int DATA_W = 69;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  stall_cnt;
   skid_state_e       state_dbg;

   int checks = 0;
   int errors = 0;

   pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_data(out_data), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_ctrl, out_data, stall_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b v=%b c=%h d=%h s=%0d required all zero",
                  in_ready, out_valid, out_ctrl, out_data, stall_cnt);
      end
      checks++;
      if (state_dbg !== ST_EMPTY) begin
         errors++; $display("FAIL reset_state: got %0d required %0d", state_dbg, ST_EMPTY);
      end
      step(); step();
      #2 rst = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_ctrl = 4'hA; in_data = DATA_W'(i);
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || out_ctrl !== 4'hA || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_%0d: got v=%b c=%h d=%h rdy=%b required v=1 c=a d=%0h rdy=1",
                     i, out_valid, out_ctrl, out_data, in_ready, i);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== DATA_W'(7)) begin
         errors++;
         $display("FAIL stream_drain: got v=%b c=%h d=%h required v=0 c=0 d=7", out_valid, out_ctrl, out_data);
      end
   endtask

   task automatic test_bubbles();
      in_valid = 1'b0; in_ctrl = 4'hF;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            errors++;
            $display("FAIL bubble_%0d: got v=%b c=%h required v=0 c=0", i, out_valid, out_ctrl);
         end
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 4'h1; in_data = 'h11;
      step();
      in_ctrl = 4'h2; in_data = 'h22;
      step();
      checks++;
      if (state_dbg !== ST_TWO || in_ready !== 1'b0 || out_data !== 'h11 || out_ctrl !== 4'h1) begin
         errors++;
         $display("FAIL bp_two: got st=%0d rdy=%b d=%h c=%h required st=2 rdy=0 d=11 c=1",
                  state_dbg, in_ready, out_data, out_ctrl);
      end
      in_ctrl = 4'h3; in_data = 'h33;
      step();
      checks++;
      if (state_dbg !== ST_TWO || in_ready !== 1'b0 || out_data !== 'h11) begin
         errors++;
         $display("FAIL bp_hold: got st=%0d rdy=%b d=%h required st=2 rdy=0 d=11", state_dbg, in_ready, out_data);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 'h22 || out_ctrl !== 4'h2 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_out_b: got v=%b d=%h c=%h rdy=%b required v=1 d=22 c=2 rdy=1",
                  out_valid, out_data, out_ctrl, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 'h33 || out_ctrl !== 4'h3) begin
         errors++;
         $display("FAIL bp_out_c: got v=%b d=%h c=%h required v=1 d=33 c=3", out_valid, out_data, out_ctrl);
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0 || stall_cnt !== 4'd2) begin
         errors++;
         $display("FAIL bp_drain: got v=%b stall=%0d required v=0 stall=2", out_valid, stall_cnt);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 4'h4; in_data = 'h44;
      step();
      in_ctrl = 4'h5; in_data = 'h55;
      step();
      flush = 1'b1; in_ctrl = 4'h6; in_data = 'h66;
      step();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1 || state_dbg !== ST_EMPTY) begin
         errors++;
         $display("FAIL flush_empty: got v=%b c=%h rdy=%b st=%0d required v=0 c=0 rdy=1 st=0",
                  out_valid, out_ctrl, in_ready, state_dbg);
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_ghost_%0d: got v=%b d=%h required v=0", i, out_valid, out_data);
         end
      end
      checks++;
      if (stall_cnt !== 4'd4) begin
         errors++; $display("FAIL flush_keeps_stall: got %0d required 4", stall_cnt);
      end
   endtask

   task automatic test_saturation();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 4'h7; in_data = 'h77;
      step();
      in_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         checks++;
         if (stall_cnt !== CNT_W'((4 + k > 15) ? 15 : 4 + k)) begin
            errors++;
            $display("FAIL sat_%0d: got %0d required %0d", k, stall_cnt, (4 + k > 15) ? 15 : 4 + k);
         end
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 'h77) begin
         errors++; $display("FAIL sat_held_entry: got v=%b d=%h required v=1 d=77", out_valid, out_data);
      end
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; in_ctrl = 4'h8; in_data = 'h88;
      step();
      in_valid = 1'b0;
      checks++;
      if (state_dbg !== ST_TWO) begin
         errors++; $display("FAIL rm_setup: got st=%0d required 2", state_dbg);
      end
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid, out_ctrl, out_data, stall_cnt} !== '0 || state_dbg !== ST_EMPTY) begin
         errors++;
         $display("FAIL rm_async_clear: got rdy=%b v=%b c=%h d=%h s=%0d st=%0d required all zero",
                  in_ready, out_valid, out_ctrl, out_data, stall_cnt, state_dbg);
      end
      step();
      #2 rst = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL rm_release: got rdy=%b v=%b required rdy=1 v=0", in_ready, out_valid);
      end
      out_ready = 1'b1;
      in_valid = 1'b1; in_ctrl = 4'h9; in_data = 'h5A;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 'h5A || out_ctrl !== 4'h9) begin
         errors++; $display("FAIL rm_fresh: got v=%b d=%h c=%h required v=1 d=5a c=9", out_valid, out_data, out_ctrl);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 'h5A || out_ctrl !== '0) begin
         errors++; $display("FAIL rm_alone: got v=%b d=%h c=%h required v=0 d=5a c=0", out_valid, out_data, out_ctrl);
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_bubbles();
      test_backpressure();
      test_flush();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
